vid_timing_gen: RTL and testbench
=================================

// Module: vid_timing_gen
// PURPOSE
//  Parametrised raster timing generator for the DVI/HDMI transmit path. Produces pixel
//  coordinates, DE, HSYNC/VSYNC with configurable polarity, blanking and line/frame strobes
//  for any CEA/VESA mode. Sits between the pixel clock domain and the pattern source / TMDS
//  encoders. OUT_DELAY aligns its outputs with downstream pipeline latency.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FRONT    16   horizontal front porch (pixels)
//  H_SYNC     96   hsync pulse width (pixels)
//  H_BACK     48   horizontal back porch (pixels)
//  V_ACTIVE   480  visible lines per frame
//  V_FRONT    10   vertical front porch (lines)
//  V_SYNC     2    vsync pulse width (lines)
//  V_BACK     33   vertical back porch (lines)
//  HSYNC_POL  0    asserted hsync level (0 = active-low)
//  VSYNC_POL  0    asserted vsync level (0 = active-low)
//  CW         10   coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
//  OUT_DELAY  1    output register stages, >= 1
//  FC_W       16   frame counter width (VTG_FRAME_COUNT_EN only)
// PORTS
//  pxl_clk      in   1     pixel clock
//  rst          in   1     synchronous reset, active-high
//  ce           in   1     pixel advance enable; counters/pipeline move only when 1
//  x            out  CW    horizontal position, 0..H_TOTAL-1
//  y            out  CW    vertical position, 0..V_TOTAL-1
//  de           out  1     x < H_ACTIVE && y < V_ACTIVE
//  hsync        out  1     horizontal sync, level per HSYNC_POL
//  vsync        out  1     vertical sync, level per VSYNC_POL
//  vblank       out  1     y >= V_ACTIVE
//  line_start   out  1     x == 0
//  frame_start  out  1     x == 0 && y == 0
//  frame_cnt    out  FC_W  completed frame count (VTG_FRAME_COUNT_EN only)
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Any zero-width field, or
//    CW too narrow for either total, or OUT_DELAY < 1 is an elaboration error.
//  - Counters: on ce, x increments; at x == H_TOTAL-1 x wraps to 0 and y increments; at
//    y == V_TOTAL-1 and x == H_TOTAL-1 both wrap to 0. ce=0: counters hold.
//  - Decode per counter value: hsync asserted for H_ACTIVE+H_FRONT <= x <
//    H_ACTIVE+H_FRONT+H_SYNC. vsync edges aligned to hsync leading edge: asserts at
//    (x=H_ACTIVE+H_FRONT, y=V_ACTIVE+V_FRONT), deasserts at same x on
//    y=V_ACTIVE+V_FRONT+V_SYNC; exactly V_SYNC*H_TOTAL pixel periods.
//  - All outputs registered: OUT_DELAY clock-enabled stages; output reflects counter value
//    OUT_DELAY ce-cycles earlier. Every stage holds while ce=0; consumers qualify with ce.
//  - line_start/frame_start: high for exactly one pixel (one ce-qualified sample).
//  - Reset: counters = (0,0); every pipeline stage flushed to x=0, y=0, de=0, vblank=0,
//    line_start=0, frame_start=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL. rst dominates ce.
//    First ce after rst release loads (0,0) decode; it appears at outputs OUT_DELAY ce
//    cycles later with frame_start=line_start=de=1. Reset mid-frame restarts cleanly; no
//    partial sync pulse is extended.
// CONFIGURATION
//  VTG_FRAME_COUNT_EN defined: frame_cnt port present; reset 0; increments by 1
//  coincident with each output frame_start except the first after reset; wraps 2^FC_W-1
//  -> 0; aligned with other outputs.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Defaults, ce=1, rst 1->0: first output (x0,y0) de=1 frame_start=1 line_start=1;
//    de=1 at x=639, de=0 at x=640; x wraps 799->0 with y+1.
//  2 ce=1, full line: hsync low exactly x=656..751 (96 clocks), high else; line_start once
//    per 800 clocks.
//  3 Full frame: vsync low from (656,490) to (655,492) = 1600 clocks; vblank=1 for
//    y=480..524; frame_start period 420000 clocks.
//  4 ce alternating 1/0: frame_start period 840000 clocks; all outputs hold on ce=0.
//  5 rst pulse at (300,200) mid-frame: outputs at reset values during rst; next output
//    (0,0) with frame_start=1; OUT_DELAY=3 shows 3 ce-cycle latency.
//  6 HSYNC_POL=VSYNC_POL=1: sync levels inverted; with VTG_FRAME_COUNT_EN, FC_W=2:
//    frame_cnt 0,1,2,3,0 on successive frame_starts.

Source files
------------

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: raster timing generator for the DVI/HDMI transmit path.
// Produces pixel coordinates, DE, HSYNC/VSYNC, vertical blanking and
// line/frame strobes for any CEA/VESA mode. All outputs leave through an
// OUT_DELAY-deep clock-enabled register pipeline so they can be lined up with
// downstream pipeline latency.
//
// Optional feature macro: VTG_FRAME_COUNT_EN
//   defined   -> frame_cnt port and completed-frame counter are present
//   undefined -> no frame_cnt port; everything else identical
//
// Reset is synchronous, active-high, and dominates ce.

module vid_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CW        = 10,
    parameter int OUT_DELAY = 1,
    parameter int FC_W      = 16
) (
    input  logic          pxl_clk,
    input  logic          rst,
    input  logic          ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          vblank,
    output logic          line_start,
    output logic          frame_start
`ifdef VTG_FRAME_COUNT_EN
    ,
    output logic [FC_W-1:0] frame_cnt
`endif
);

    localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_BEGIN  = H_ACTIVE + H_FRONT;
    localparam int HS_FINISH = HS_BEGIN + H_SYNC;
    localparam int VS_BEGIN  = V_ACTIVE + V_FRONT;
    localparam int VS_FINISH = VS_BEGIN + V_SYNC;

    // Compare constants sized to the counters so every decode compare is CW wide.
    localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C     = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEGIN_C  = CW'(HS_BEGIN);
    localparam logic [CW-1:0] HS_FINISH_C = CW'(HS_FINISH);
    localparam logic [CW-1:0] VS_BEGIN_C  = CW'(VS_BEGIN);
    localparam logic [CW-1:0] VS_FINISH_C = CW'(VS_FINISH);

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    // Configuration sanity: reject modes the counters or pipeline cannot represent.
    generate
        if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_timing
            $error("vid_timing_gen: every horizontal and vertical timing field must be >= 1");
        end
        if (CW < 1 || CW > 62 ||
            longint'(H_TOTAL) > (64'd1 << CW) ||
            longint'(V_TOTAL) > (64'd1 << CW)) begin : g_bad_cw
            $error("vid_timing_gen: CW cannot hold H_TOTAL-1 and V_TOTAL-1");
        end
        if (OUT_DELAY < 1) begin : g_bad_delay
            $error("vid_timing_gen: OUT_DELAY must be >= 1");
        end
        if (FC_W < 1) begin : g_bad_fcw
            $error("vid_timing_gen: FC_W must be >= 1");
        end
    endgenerate

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          de;
        logic          hsync;
        logic          vsync;
        logic          vblank;
        logic          line_start;
        logic          frame_start;
    } sample_t;

    // Value every pipeline stage takes under reset: blank, syncs deasserted.
    localparam sample_t RST_SAMPLE = '{
        x:           '0,
        y:           '0,
        de:          1'b0,
        hsync:       ~HS_ON,
        vsync:       ~VS_ON,
        vblank:      1'b0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          hs_active;
    logic          vs_active;
    sample_t       dec;
    sample_t       pipe [OUT_DELAY];

    // Raster position: x runs across the line, y steps at end of each line.
    always_ff @(posedge pxl_clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // hsync window is purely horizontal.
    assign hs_active = (h_cnt >= HS_BEGIN_C) && (h_cnt < HS_FINISH_C);

    // vsync edges follow the hsync leading edge, so the pulse spans the tail of
    // the first sync line, any whole lines between, and the head of the line
    // where it ends: exactly V_SYNC full line periods.
    assign vs_active = ((v_cnt == VS_BEGIN_C) && (h_cnt >= HS_BEGIN_C)) ||
                       ((v_cnt >  VS_BEGIN_C) && (v_cnt <  VS_FINISH_C)) ||
                       ((v_cnt == VS_FINISH_C) && (h_cnt < HS_BEGIN_C));

    // Decode the current raster position into one output sample.
    always_comb begin
        dec             = RST_SAMPLE;
        dec.x           = h_cnt;
        dec.y           = v_cnt;
        dec.de          = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        dec.hsync       = hs_active ? HS_ON : ~HS_ON;
        dec.vsync       = vs_active ? VS_ON : ~VS_ON;
        dec.vblank      = (v_cnt >= V_ACT_C);
        dec.line_start  = (h_cnt == '0);
        dec.frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    // Output pipeline: all stages advance together on ce and flush on reset.
    always_ff @(posedge pxl_clk) begin
        if (rst) begin
            for (int i = 0; i < OUT_DELAY; i++) begin
                pipe[i] <= RST_SAMPLE;
            end
        end else if (ce) begin
            pipe[0] <= dec;
            for (int i = 1; i < OUT_DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign x           = pipe[OUT_DELAY-1].x;
    assign y           = pipe[OUT_DELAY-1].y;
    assign de          = pipe[OUT_DELAY-1].de;
    assign hsync       = pipe[OUT_DELAY-1].hsync;
    assign vsync       = pipe[OUT_DELAY-1].vsync;
    assign vblank      = pipe[OUT_DELAY-1].vblank;
    assign line_start  = pipe[OUT_DELAY-1].line_start;
    assign frame_start = pipe[OUT_DELAY-1].frame_start;

`ifdef VTG_FRAME_COUNT_EN
    // frame_start about to enter the final stage; counting it here keeps
    // frame_cnt aligned with the frame_start it belongs to.
    logic fs_into_last;
    logic fs_seen;

    generate
        if (OUT_DELAY == 1) begin : g_fs_direct
            assign fs_into_last = dec.frame_start;
        end else begin : g_fs_piped
            assign fs_into_last = pipe[OUT_DELAY-2].frame_start;
        end
    endgenerate

    // Count completed frames; the first frame_start after reset opens frame 0.
    always_ff @(posedge pxl_clk) begin
        if (rst) begin
            frame_cnt <= '0;
            fs_seen   <= 1'b0;
        end else if (ce && fs_into_last) begin
            if (fs_seen) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            fs_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen. Three instances share one clock:
//   0: default 640x480 mode, OUT_DELAY=1 (line-level probes)
//   1: tiny 15x8 mode, OUT_DELAY=1, active-low syncs (frame, vsync, ce gating)
//   2: tiny 15x8 mode, OUT_DELAY=3, active-high syncs, FC_W=2 (latency, reset, frame_cnt)
// A scoreboard recomputes every output sample from a pixel-index model.

module tb_vid_timing_gen;

    localparam int N = 3;
    localparam int HA [N] = '{640, 8, 8};
    localparam int HF [N] = '{16, 2, 2};
    localparam int HS [N] = '{96, 3, 3};
    localparam int HB [N] = '{48, 2, 2};
    localparam int VA [N] = '{480, 4, 4};
    localparam int VF [N] = '{10, 1, 1};
    localparam int VS [N] = '{2, 2, 2};
    localparam int VB [N] = '{33, 1, 1};
    localparam int HP [N] = '{0, 0, 1};
    localparam int VP [N] = '{0, 0, 1};
    localparam int OD [N] = '{1, 1, 3};
`ifdef VTG_FRAME_COUNT_EN
    localparam bit FC_ON = 1'b1;
`else
    localparam bit FC_ON = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       hs;
        logic       vs;
        logic       vb;
        logic       ls;
        logic       fs;
        logic [1:0] fc;
    } smp_t;

    typedef struct {
        int   n;
        int   x;
        int   y;
        logic de;
        logic hs;
        logic ls;
        logic fs;
    } vec_t;

    logic           clk = 1'b0;
    logic [N-1:0]   rst_v;
    logic [N-1:0]   ce_v;
    logic [9:0]     ox [N];
    logic [9:0]     oy [N];
    logic           ode [N];
    logic           ohs [N];
    logic           ovs [N];
    logic           ovb [N];
    logic           ols [N];
    logic           ofs [N];
    logic [15:0]    fca;
    logic [15:0]    fcb;
    logic [1:0]     fcc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vid_timing_gen #(
        .H_ACTIVE(HA[0]), .H_FRONT(HF[0]), .H_SYNC(HS[0]), .H_BACK(HB[0]),
        .V_ACTIVE(VA[0]), .V_FRONT(VF[0]), .V_SYNC(VS[0]), .V_BACK(VB[0]),
        .HSYNC_POL(HP[0]), .VSYNC_POL(VP[0]), .CW(10), .OUT_DELAY(OD[0]), .FC_W(16)
    ) dut_a (
        .pxl_clk(clk), .rst(rst_v[0]), .ce(ce_v[0]),
        .x(ox[0]), .y(oy[0]), .de(ode[0]), .hsync(ohs[0]), .vsync(ovs[0]),
        .vblank(ovb[0]), .line_start(ols[0]), .frame_start(ofs[0])
`ifdef VTG_FRAME_COUNT_EN
        , .frame_cnt(fca)
`endif
    );

    vid_timing_gen #(
        .H_ACTIVE(HA[1]), .H_FRONT(HF[1]), .H_SYNC(HS[1]), .H_BACK(HB[1]),
        .V_ACTIVE(VA[1]), .V_FRONT(VF[1]), .V_SYNC(VS[1]), .V_BACK(VB[1]),
        .HSYNC_POL(HP[1]), .VSYNC_POL(VP[1]), .CW(10), .OUT_DELAY(OD[1]), .FC_W(16)
    ) dut_b (
        .pxl_clk(clk), .rst(rst_v[1]), .ce(ce_v[1]),
        .x(ox[1]), .y(oy[1]), .de(ode[1]), .hsync(ohs[1]), .vsync(ovs[1]),
        .vblank(ovb[1]), .line_start(ols[1]), .frame_start(ofs[1])
`ifdef VTG_FRAME_COUNT_EN
        , .frame_cnt(fcb)
`endif
    );

    vid_timing_gen #(
        .H_ACTIVE(HA[2]), .H_FRONT(HF[2]), .H_SYNC(HS[2]), .H_BACK(HB[2]),
        .V_ACTIVE(VA[2]), .V_FRONT(VF[2]), .V_SYNC(VS[2]), .V_BACK(VB[2]),
        .HSYNC_POL(HP[2]), .VSYNC_POL(VP[2]), .CW(10), .OUT_DELAY(OD[2]), .FC_W(2)
    ) dut_c (
        .pxl_clk(clk), .rst(rst_v[2]), .ce(ce_v[2]),
        .x(ox[2]), .y(oy[2]), .de(ode[2]), .hsync(ohs[2]), .vsync(ovs[2]),
        .vblank(ovb[2]), .line_start(ols[2]), .frame_start(ofs[2])
`ifdef VTG_FRAME_COUNT_EN
        , .frame_cnt(fcc)
`endif
    );

    function automatic int htot(int d);
        return HA[d] + HF[d] + HS[d] + HB[d];
    endfunction

    function automatic int vtot(int d);
        return VA[d] + VF[d] + VS[d] + VB[d];
    endfunction

    function automatic smp_t reset_smp(int d);
        smp_t s;
        s = '0;
        s.hs = (HP[d] == 0);
        s.vs = (VP[d] == 0);
        return s;
    endfunction

    // Expected sample for raster position (mx,my), vsync from linear pixel index.
    function automatic smp_t model(int d, int mx, int my, logic [1:0] fc);
        smp_t s;
        int   ht, hs0, p, vs0;
        bit   hs_on, vs_on;
        ht    = htot(d);
        hs0   = HA[d] + HF[d];
        p     = my * ht + mx;
        vs0   = (VA[d] + VF[d]) * ht + hs0;
        hs_on = (mx >= hs0) && (mx < hs0 + HS[d]);
        vs_on = (p >= vs0) && (p < vs0 + VS[d] * ht);
        s.x   = 10'(mx);
        s.y   = 10'(my);
        s.de  = (mx < HA[d]) && (my < VA[d]);
        s.hs  = hs_on ? (HP[d] != 0) : (HP[d] == 0);
        s.vs  = vs_on ? (VP[d] != 0) : (VP[d] == 0);
        s.vb  = (my >= VA[d]);
        s.ls  = (mx == 0);
        s.fs  = (mx == 0) && (my == 0);
        s.fc  = fc;
        return s;
    endfunction

    function automatic smp_t observe(int d);
        smp_t s;
        s.x  = ox[d];
        s.y  = oy[d];
        s.de = ode[d];
        s.hs = ohs[d];
        s.vs = ovs[d];
        s.vb = ovb[d];
        s.ls = ols[d];
        s.fs = ofs[d];
        s.fc = (d == 2) ? fcc : 2'd0;
        return s;
    endfunction

    task automatic check_smp(string name, smp_t act, smp_t exp, bit use_fc);
        if (!use_fc) begin
            act.fc = '0;
            exp.fc = '0;
        end
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b vb=%b ls=%b fs=%b fc=%0d, required x=%0d y=%0d de=%b hs=%b vs=%b vb=%b ls=%b fs=%b fc=%0d",
                     name, act.x, act.y, act.de, act.hs, act.vs, act.vb, act.ls, act.fs, act.fc,
                     exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.vb, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Scoreboard state per instance
    smp_t         sbq [N][$];
    smp_t         last [N];
    int           mx [N];
    int           my [N];
    logic [1:0]   mfc [N];
    bit           mseen [N];
    bit           armed [N] = '{0, 0, 0};
    logic [N-1:0] sb_r;
    logic [N-1:0] sb_c;

    // Expected samples are queued as each ce edge is applied and popped when
    // that edge's output appears; prefill models the reset-filled stages.
    always @(posedge clk) begin
        sb_r = rst_v;
        sb_c = ce_v;
        #1;
        for (int d = 0; d < N; d++) begin
            if (sb_r[d]) begin
                sbq[d].delete();
                for (int k = 0; k < OD[d] - 1; k++) sbq[d].push_back(reset_smp(d));
                mx[d]    = 0;
                my[d]    = 0;
                mfc[d]   = 2'd0;
                mseen[d] = 1'b0;
                armed[d] = 1'b1;
                last[d]  = reset_smp(d);
                check_smp($sformatf("reset_%0d", d), observe(d), last[d], FC_ON && d == 2);
            end else if (armed[d]) begin
                if (sb_c[d]) begin
                    if (mx[d] == 0 && my[d] == 0) begin
                        if (mseen[d]) mfc[d] = mfc[d] + 2'd1;
                        mseen[d] = 1'b1;
                    end
                    sbq[d].push_back(model(d, mx[d], my[d], mfc[d]));
                    if (mx[d] == htot(d) - 1) begin
                        mx[d] = 0;
                        my[d] = (my[d] == vtot(d) - 1) ? 0 : my[d] + 1;
                    end else begin
                        mx[d] = mx[d] + 1;
                    end
                    last[d] = sbq[d].pop_front();
                    check_smp($sformatf("pipe_%0d", d), observe(d), last[d], FC_ON && d == 2);
                end else begin
                    check_smp($sformatf("hold_%0d", d), observe(d), last[d], FC_ON && d == 2);
                end
            end
        end
    end

    vec_t tbl [10];

    initial begin
        int   k, hl, lsn, den, cnt, vsl, vbn, vsf, first, per, nfs;
        logic prev, prev_vs;
        smp_t e;
        int   fcs [5];
        int   pos [5];

        // {ce edges since release, x, y, de, hsync, line_start, frame_start}
        tbl[0] = '{1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{2,   1,   0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{640, 639, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{641, 640, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{656, 655, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{657, 656, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{752, 751, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{753, 752, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{800, 799, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{801, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_v = '1;
        ce_v  = '0;
        repeat (3) @(negedge clk);

        // Default mode: probe points along the first line
        rst_v[0] = 1'b0;
        ce_v[0]  = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            while (k < tbl[i].n) begin
                @(posedge clk);
                k++;
            end
            #1;
            e = '0;
            e.x = 10'(tbl[i].x); e.y = 10'(tbl[i].y);
            e.de = tbl[i].de; e.hs = tbl[i].hs; e.vs = 1'b1;
            e.ls = tbl[i].ls; e.fs = tbl[i].fs;
            check_smp($sformatf("probe_n%0d", tbl[i].n), observe(0), e, 1'b0);
        end

        // One full line: hsync width, DE width, one line_start
        hl = 0; lsn = 0; den = 0;
        repeat (800) begin
            @(posedge clk); #1;
            if (ohs[0] == 1'b0) hl++;
            if (ols[0]) lsn++;
            if (ode[0]) den++;
        end
        check_int("line_hsync_low", hl, 96);
        check_int("line_start_count", lsn, 1);
        check_int("line_de_count", den, 640);
        @(negedge clk);
        ce_v[0] = 1'b0;

        // Tiny mode, ce=1: frame period, vsync width/contiguity, vblank lines
        rst_v[1] = 1'b0;
        ce_v[1]  = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!ofs[1] && cnt < 500);
        check_int("b_first_fs_edge", cnt, 1);
        cnt = 0; vsl = 0; vbn = 0; vsf = 0; prev_vs = ovs[1];
        do begin
            @(posedge clk); #1;
            cnt++;
            if (!ovs[1]) vsl++;
            if (ovb[1]) vbn++;
            if (prev_vs && !ovs[1]) vsf++;
            prev_vs = ovs[1];
        end while (!ofs[1] && cnt < 500);
        check_int("b_frame_period", cnt, 120);
        check_int("b_vsync_low", vsl, 30);
        check_int("b_vsync_pulses", vsf, 1);
        check_int("b_vblank_count", vbn, 60);

        // ce alternating: frame period doubles in clocks
        prev = ofs[1]; first = -1; per = -1; cnt = 0;
        for (int i = 0; i < 1000 && per < 0; i++) begin
            @(negedge clk);
            ce_v[1] = ~ce_v[1];
            @(posedge clk); #1;
            cnt++;
            if (ofs[1] && !prev) begin
                if (first < 0) first = cnt;
                else per = cnt - first;
            end
            prev = ofs[1];
        end
        check_int("b_alt_ce_period", per, 240);

        // Random ce pattern, scoreboard only
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ce_v[1] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        ce_v[1] = 1'b0;

        // OUT_DELAY=3, inverted syncs: two reset samples before (0,0)
        rst_v[2] = 1'b0;
        ce_v[2]  = 1'b1;
        @(posedge clk); #1;
        check_int("c_lat_edge1_fs", int'(ofs[2]), 0);
        check_int("c_lat_edge1_hs", int'(ohs[2]), 0);
        @(posedge clk); #1;
        check_int("c_lat_edge2_fs", int'(ofs[2]), 0);
        @(posedge clk); #1;
        check_int("c_lat_edge3_fs", int'(ofs[2]), 1);
        check_int("c_lat_edge3_de", int'(ode[2]), 1);
        check_int("c_lat_edge3_ls", int'(ols[2]), 1);

        // Run into the vsync pulse, then reset mid-pulse
        repeat (92) @(posedge clk);
        #1;
        check_int("c_in_vsync", int'(ovs[2]), 1);
        @(negedge clk);
        rst_v[2] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_int("c_rst_vsync", int'(ovs[2]), 0);
        end
        @(negedge clk);
        rst_v[2] = 1'b0;

        // Restart: frame_start latency and frame_cnt sequence over five frames
        prev = 1'b0; cnt = 0; nfs = 0;
        for (int i = 0; i < 1000 && nfs < 5; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (ofs[2] && !prev) begin
                pos[nfs] = cnt;
                fcs[nfs] = int'(fcc);
                nfs++;
            end
            prev = ofs[2];
        end
        check_int("c_fs_count", nfs, 5);
        check_int("c_restart_latency", pos[0], 3);
        check_int("c_frame_period", pos[1] - pos[0], 120);
        if (FC_ON) begin
            for (int i = 0; i < 5; i++) begin
                check_int($sformatf("c_frame_cnt_%0d", i), fcs[i], i % 4);
            end
        end

        @(negedge clk);
        ce_v = '0;
        repeat (4) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
